// File: rtl/gcd_lcm_coproc_if.sv
// Start/Done coprocessor handshake between the core (master) and the GCD/LCM unit (slave).
interface gcd_lcm_coproc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Funct;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Ovf;

  modport master (
    output Start, SrcA, SrcB, Funct,
    input  Busy, Done, Result, Ovf
  );

  modport slave (
    input  Start, SrcA, SrcB, Funct,
    output Busy, Done, Result, Ovf
  );
endinterface

// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD (binary Stein) / LCM coprocessor: LCM = A0 * (B0 / GCD) via a
// restoring divider followed by a single-cycle multiply.
module gcd_lcm_coproc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned KW    = 6
) (
  input logic             clk,
  input logic             reset,
  gcd_lcm_coproc_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StGcd, StDiv, StMul, StFin} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a0_q, b0_q;
  logic               f_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [KW-1:0]      k_q;
  logic [WIDTH-1:0]   g_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   rem_q;
  logic [KW-1:0]      cnt_q;
  logic [WIDTH-1:0]   l_q;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;
  logic               ovf_q;

  // Partial remainder is one bit wider than the divisor so the trial compare cannot wrap.
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [2*WIDTH-1:0] prod;

  assign trial = {rem_q, q_q[WIDTH-1]};
  assign fits  = (trial >= {1'b0, g_q});
  assign prod  = {{WIDTH{1'b0}}, a0_q} * {{WIDTH{1'b0}}, q_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          state_d = ((bus.SrcA == '0) || (bus.SrcB == '0)) ? StFin : StGcd;
        end
      end
      StGcd: begin
        if (a_q == b_q) begin
          state_d = f_q ? StDiv : StFin;
        end
      end
      StDiv: begin
        if (cnt_q == KW'(WIDTH - 1)) begin
          state_d = StMul;
        end
      end
      StMul:   state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.Busy   = (state_q != StIdle);
    bus.Done   = done_q;
    bus.Result = result_q;
    bus.Ovf    = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a0_q     <= '0;
      b0_q     <= '0;
      f_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      g_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      l_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StFin);
      unique case (state_q)
        StIdle: begin
          if (bus.Start) begin
            a0_q  <= bus.SrcA;
            b0_q  <= bus.SrcB;
            f_q   <= bus.Funct;
            a_q   <= bus.SrcA;
            b_q   <= bus.SrcB;
            k_q   <= '0;
            ovf_q <= 1'b0;
            // Zero-operand shortcut: G is the other operand and the LCM is 0.
            g_q   <= bus.SrcA | bus.SrcB;
            l_q   <= '0;
          end
        end
        StGcd: begin
          if (a_q == b_q) begin
            g_q   <= a_q << k_q;
            q_q   <= b0_q;
            rem_q <= '0;
            cnt_q <= '0;
          end else if (!a_q[0] && !b_q[0]) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KW'(1);
          end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (!b_q[0]) begin
            b_q <= b_q >> 1;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        StDiv: begin
          // q_q shifts dividend bits out at the top and quotient bits in at the bottom.
          rem_q <= fits ? WIDTH'(trial - {1'b0, g_q}) : trial[WIDTH-1:0];
          q_q   <= {q_q[WIDTH-2:0], fits};
          cnt_q <= cnt_q + KW'(1);
        end
        StMul: begin
          l_q   <= prod[WIDTH-1:0];
          ovf_q <= |prod[2*WIDTH-1:WIDTH];
        end
        StFin: begin
          result_q <= f_q ? l_q : g_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed self-checking bench for gcd_lcm_coproc with hand-computed results and latencies.
module tb_gcd_lcm_coproc;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  gcd_lcm_coproc_if #(.WIDTH(32)) bus ();

  gcd_lcm_coproc #(.WIDTH(32), .KW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Issue one request; returns at the negedge of the Done cycle (lat = -1 on timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic f,
                       output int lat, output logic busy1);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.Funct = f;
    @(negedge clk);
    bus.Start = 1'b0;
    busy1 = bus.Busy;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      if (bus.Done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.Busy); else passed++;
    total++; if (bus.Done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.Done); else passed++;
    total++; if (bus.Result !== 32'd0) $display("FAIL reset_result got %0d want 0", bus.Result); else passed++;
    total++; if (bus.Ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.Ovf); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_gcd();
    int   lat;
    logic busy1;
    // gcd(48,18): 7 GCD cycles -> Done 9 cycles after Start
    do_op(32'd48, 32'd18, 1'b0, lat, busy1);
    total++; if (busy1 !== 1'b1) $display("FAIL gcd_busy got %b want 1", busy1); else passed++;
    total++; if (lat !== 9) $display("FAIL gcd_latency got %0d want 9", lat); else passed++;
    total++; if (bus.Result !== 32'd6) $display("FAIL gcd_result got %0d want 6", bus.Result); else passed++;
    total++; if (bus.Ovf !== 1'b0) $display("FAIL gcd_ovf got %b want 0", bus.Ovf); else passed++;
    total++; if (bus.Busy !== 1'b0) $display("FAIL gcd_busy_at_done got %b want 0", bus.Busy); else passed++;
    @(negedge clk);
    total++; if (bus.Done !== 1'b0) $display("FAIL gcd_done_pulse got %b want 0", bus.Done); else passed++;
    repeat (3) @(negedge clk);
    total++; if (bus.Result !== 32'd6) $display("FAIL gcd_result_hold got %0d want 6", bus.Result); else passed++;
  endtask

  task automatic test_lcm();
    int   lat;
    logic busy1;
    // lcm(4,6): 5 GCD cycles (G=2) + 35 -> 40
    do_op(32'd4, 32'd6, 1'b1, lat, busy1);
    total++; if (lat !== 40) $display("FAIL lcm_latency got %0d want 40", lat); else passed++;
    total++; if (bus.Result !== 32'd12) $display("FAIL lcm_result got %0d want 12", bus.Result); else passed++;
    total++; if (bus.Ovf !== 1'b0) $display("FAIL lcm_ovf got %b want 0", bus.Ovf); else passed++;
  endtask

  task automatic test_zero();
    logic [31:0] va [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] vb [3] = '{32'd7, 32'd0, 32'd5};
    logic        vf [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] vr [3] = '{32'd7, 32'd0, 32'd0};
    int   lat;
    logic busy1;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vf[i], lat, busy1);
      total++; if (lat !== 2) $display("FAIL zero%0d_latency got %0d want 2", i, lat); else passed++;
      total++; if (bus.Result !== vr[i]) $display("FAIL zero%0d_result got %0d want %0d", i, bus.Result, vr[i]); else passed++;
      total++; if (bus.Ovf !== 1'b0) $display("FAIL zero%0d_ovf got %b want 0", i, bus.Ovf); else passed++;
    end
  endtask

  task automatic test_ovf();
    int   lat;
    logic busy1;
    // 65536*65537 = 2^32 + 2^16; 34 GCD cycles + 35
    do_op(32'd65536, 32'd65537, 1'b1, lat, busy1);
    total++; if (lat !== 69) $display("FAIL ovf_latency got %0d want 69", lat); else passed++;
    total++; if (bus.Result !== 32'd65536) $display("FAIL ovf_result got %0d want 65536", bus.Result); else passed++;
    total++; if (bus.Ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", bus.Ovf); else passed++;
  endtask

  task automatic test_boundary();
    int   lat;
    logic busy1;
    // 31 subtract/shift pairs + final equal cycle = 63 GCD cycles
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, busy1);
    total++; if (lat !== 65) $display("FAIL bnd_gcd_latency got %0d want 65", lat); else passed++;
    total++; if (bus.Result !== 32'd1) $display("FAIL bnd_gcd_result got %0d want 1", bus.Result); else passed++;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, busy1);
    total++; if (lat !== 36) $display("FAIL bnd_lcm_latency got %0d want 36", lat); else passed++;
    total++; if (bus.Result !== 32'hFFFF_FFFF) $display("FAIL bnd_lcm_result got %h want ffffffff", bus.Result); else passed++;
    total++; if (bus.Ovf !== 1'b0) $display("FAIL bnd_lcm_ovf got %b want 0", bus.Ovf); else passed++;
  endtask

  task automatic test_busy_start();
    int lat = -1;
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd48; bus.SrcB = 32'd18; bus.Funct = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd100; bus.SrcB = 32'd75; bus.Funct = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int c = 3; c <= 200; c++) begin
      if (bus.Done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    total++; if (lat !== 9) $display("FAIL busy_start_latency got %0d want 9", lat); else passed++;
    total++; if (bus.Result !== 32'd6) $display("FAIL busy_start_result got %0d want 6", bus.Result); else passed++;
    total++; if (bus.Ovf !== 1'b0) $display("FAIL busy_start_ovf got %b want 0", bus.Ovf); else passed++;
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic busy1;
    do_op(32'd4, 32'd6, 1'b0, lat, busy1);
    total++; if (bus.Result !== 32'd2) $display("FAIL b2b_first got %0d want 2", bus.Result); else passed++;
    // Start raised in the Done cycle itself
    bus.Start = 1'b1; bus.SrcA = 32'd0; bus.SrcB = 32'd9; bus.Funct = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    total++; if (bus.Busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", bus.Busy); else passed++;
    @(negedge clk);
    total++; if (bus.Done !== 1'b1) $display("FAIL b2b_done got %b want 1", bus.Done); else passed++;
    total++; if (bus.Result !== 32'd9) $display("FAIL b2b_result got %0d want 9", bus.Result); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int dones = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd4; bus.SrcB = 32'd6; bus.Funct = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    // GCD occupies cycles 1..5, so cycle 10 is inside DIV
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.Busy !== 1'b0) $display("FAIL rst_div_busy got %b want 0", bus.Busy); else passed++;
    total++; if (bus.Result !== 32'd0) $display("FAIL rst_div_result got %0d want 0", bus.Result); else passed++;
    for (int c = 0; c < 50; c++) begin
      if (bus.Done === 1'b1) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 0) $display("FAIL rst_div_done got %0d pulses want 0", dones); else passed++;
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    bus.Funct = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_gcd();
    test_lcm();
    test_zero();
    test_ovf();
    test_boundary();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
